// File: rtl/flexsoc_reset_pkg.sv
// rtl/flexsoc_reset_pkg.sv - shared types and constants for the flexsoc reset sequencer
package flexsoc_reset_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_LOCK,
    HOLD_POR,
    HOLD_SYS,
    RUN,
    SYS_RST
  } rst_state_e;

  localparam logic [1:0] CAUSE_PIN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_SYS  = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous active-low clear
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/flexsoc_reset_seq.sv
// rtl/flexsoc_reset_seq.sv - orders PORESETn/HRESETn release after PLL lock, services SYSRESETREQ
module flexsoc_reset_seq
  import flexsoc_reset_pkg::*;
#(
  parameter int NUM_LOCK         = 2,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int POR_HOLD_CYCLES  = 255,
  parameter int SYS_DELAY_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [NUM_LOCK-1:0] PLL_LOCKED,
  input  logic                SYSRESETREQ,
  output logic                PORESETn,
  output logic                HRESETn,
  output logic [1:0]          RESET_CAUSE
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, POR_HOLD_CYCLES, SYS_DELAY_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_DELAY_CYCLES - 1);

  logic                rst_int_n;
  logic [NUM_LOCK-1:0] lock_sync;
  logic                lock_ok;
  logic                lock_lost;

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             por_q, por_d;
  logic             hres_q, hres_d;
  logic [1:0]       cause_q, cause_d;

  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  // Lock flops stay cleared until the internal reset releases, so debounce starts from zero.
  sync_2ff #(.WIDTH(NUM_LOCK)) u_lock_sync (
    .clk   (CLK),
    .rst_n (rst_int_n),
    .d     (PLL_LOCKED),
    .q     (lock_sync)
  );

  assign lock_ok   = &lock_sync;
  assign lock_lost = !lock_ok && (state_q inside {HOLD_POR, HOLD_SYS, RUN, SYS_RST});

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      por_q   <= 1'b0;
      hres_q  <= 1'b0;
      cause_q <= CAUSE_PIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      por_q   <= por_d;
      hres_q  <= hres_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    por_d   = por_q;
    hres_d  = hres_q;
    cause_d = cause_q;
    if (lock_lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      por_d   = 1'b0;
      hres_d  = 1'b0;
      cause_d = CAUSE_LOCK;
    end else begin
      case (state_q)
        ASSERT: begin
          cnt_d = '0;
          if (rst_int_n) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (!lock_ok) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = HOLD_POR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD_POR: begin
          if (cnt_q == POR_LAST) begin
            state_d = HOLD_SYS;
            cnt_d   = '0;
            por_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD_SYS, SYS_RST: begin
          // SYSRESETREQ is deliberately not looked at while the pulse is running.
          if (cnt_q == SYS_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            hres_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (SYSRESETREQ) begin
            state_d = SYS_RST;
            cnt_d   = '0;
            hres_d  = 1'b0;
            cause_d = CAUSE_SYS;
          end
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign PORESETn    = por_q;
  assign HRESETn     = hres_q;
  assign RESET_CAUSE = cause_q;

endmodule

// File: tb/tb_flexsoc_reset_seq.sv
// tb/tb_flexsoc_reset_seq.sv - self-checking bench for flexsoc_reset_seq
module tb_flexsoc_reset_seq;

  localparam int D = 4;
  localparam int P = 8;
  localparam int S = 3;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic [1:0] PLL_LOCKED = 2'b00;
  logic       SYSRESETREQ = 1'b0;
  logic       PORESETn;
  logic       HRESETn;
  logic [1:0] RESET_CAUSE;

  int checks = 0;
  int errors = 0;

  flexsoc_reset_seq #(
    .NUM_LOCK         (2),
    .DEBOUNCE_CYCLES  (D),
    .POR_HOLD_CYCLES  (P),
    .SYS_DELAY_CYCLES (S)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .PLL_LOCKED  (PLL_LOCKED),
    .SYSRESETREQ (SYSRESETREQ),
    .PORESETn    (PORESETn),
    .HRESETn     (HRESETn),
    .RESET_CAUSE (RESET_CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs follow from how many edges lock_ok has been seen high
  // since the last reset or lock loss, plus a countdown for a requested HRESETn pulse.
  int         m_k = 0;
  int         m_run = 0;
  int         m_pulse = 0;
  logic [1:0] m_cause = 2'b01;
  logic [3:0] m_hist = 4'b0;
  logic       m_lok;
  int         n_run, n_pulse;
  logic [1:0] n_cause;
  logic       exp_por, exp_hres;

  always_comb begin
    m_lok   = (m_k + 1 >= 5) ? m_hist[(m_k - 1) % 4] : 1'b0;
    n_run   = m_run;
    n_pulse = m_pulse;
    n_cause = m_cause;
    if (!m_lok) begin
      if (m_run >= D) n_cause = 2'b10;
      n_run   = 0;
      n_pulse = 0;
    end else if (m_pulse > 0) begin
      n_pulse = m_pulse - 1;
    end else if (m_run >= D + P + S && SYSRESETREQ) begin
      n_pulse = S;
      n_cause = 2'b11;
    end else if (m_run < 1000) begin
      n_run = m_run + 1;
    end
  end

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_k     <= 0;
      m_run   <= 0;
      m_pulse <= 0;
      m_cause <= 2'b01;
      m_hist  <= 4'b0;
    end else begin
      m_k                    <= m_k + 1;
      m_hist[(m_k + 1) % 4]  <= &PLL_LOCKED;
      m_run                  <= n_run;
      m_pulse                <= n_pulse;
      m_cause                <= n_cause;
    end
  end

  assign exp_por  = (m_run >= D + P);
  assign exp_hres = (m_run >= D + P + S) && (m_pulse == 0);

  always @(negedge CLK) begin
    check("model_por", 12'(PORESETn), 12'(exp_por));
    check("model_hres", 12'(HRESETn), 12'(exp_hres));
    check("model_cause", 12'(RESET_CAUSE), 12'(m_cause));
    check("hres_implies_por", 12'(HRESETn & ~PORESETn), 12'd0);
  end

  typedef struct {
    logic       rstn;
    logic [1:0] lock;
    logic       sreq;
    int         n;
    logic       por;
    logic       hres;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[$];

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string name, input logic por, input logic hres, input logic [1:0] cause);
    check({name, "_por"}, 12'(PORESETn), 12'(por));
    check({name, "_hres"}, 12'(HRESETn), 12'(hres));
    check({name, "_cause"}, 12'(RESET_CAUSE), 12'(cause));
  endtask

  task automatic restart(input logic [1:0] lock);
    RESETn = 1'b0;
    SYSRESETREQ = 1'b0;
    PLL_LOCKED = lock;
    wait_edges(2);
    RESETn = 1'b1;
  endtask

  logic [11:0] pat;
  logic        por_all;
  int          rst_hold;
  logic [1:0]  lk;

  initial begin
    tbl.push_back(vec_t'{1'b0, 2'b11, 1'b0, 3,  1'b0, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 15, 1'b0, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 2,  1'b1, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b1, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 2,  1'b1, 1'b1, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b1, 1,  1'b1, 1'b0, 2'b11});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 2,  1'b1, 1'b0, 2'b11});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b1, 2'b11});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 2,  1'b1, 1'b1, 2'b11});
    tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 2,  1'b1, 1'b1, 2'b11});
    tbl.push_back(vec_t'{1'b1, 2'b10, 1'b0, 1,  1'b0, 1'b0, 2'b10});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 13, 1'b0, 1'b0, 2'b10});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b0, 2'b10});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b0, 2'b10});
    tbl.push_back(vec_t'{1'b0, 2'b11, 1'b0, 0,  1'b0, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b0, 2'b11, 1'b0, 2,  1'b0, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 15, 1'b0, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 1,  1'b1, 1'b0, 2'b01});
    tbl.push_back(vec_t'{1'b1, 2'b11, 1'b0, 3,  1'b1, 1'b1, 2'b01});

    for (int i = 0; i < tbl.size(); i++) begin
      RESETn      = tbl[i].rstn;
      PLL_LOCKED  = tbl[i].lock;
      SYSRESETREQ = tbl[i].sreq;
      if (tbl[i].n > 0) wait_edges(tbl[i].n);
      else #1;
      check_out($sformatf("vec%0d", i), tbl[i].por, tbl[i].hres, tbl[i].cause);
    end

    // One-cycle lock[1] glitch sampled at E5: debounce restarts, PORESETn moves from E16 to E19.
    restart(2'b11);
    wait_edges(4);
    PLL_LOCKED = 2'b01;
    wait_edges(1);
    PLL_LOCKED = 2'b11;
    wait_edges(13);
    check_out("glitch_e18", 1'b0, 1'b0, 2'b01);
    wait_edges(1);
    check_out("glitch_e19", 1'b1, 1'b0, 2'b01);

    // Lock incomplete until after E3: first good sample at E4, PORESETn after E17.
    restart(2'b01);
    wait_edges(3);
    PLL_LOCKED = 2'b11;
    wait_edges(13);
    check_out("late_lock_e16", 1'b0, 1'b0, 2'b01);
    wait_edges(1);
    check_out("late_lock_e17", 1'b1, 1'b0, 2'b01);
    wait_edges(3);
    check_out("late_lock_run", 1'b1, 1'b1, 2'b01);

    // SYSRESETREQ held for 10 edges: three-cycle pulses separated by one high cycle.
    SYSRESETREQ = 1'b1;
    pat = '0;
    por_all = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_edges(1);
      pat[i] = HRESETn;
      por_all = por_all & PORESETn;
      if (i == 9) SYSRESETREQ = 1'b0;
    end
    check("held_req_pattern", pat, 12'h888);
    check("held_req_por", 12'(por_all), 12'd1);
    check("held_req_cause", 12'(RESET_CAUSE), 12'd3);

    // Pin reset during SYS_RST: outputs drop before any clock edge.
    SYSRESETREQ = 1'b1;
    wait_edges(1);
    SYSRESETREQ = 1'b0;
    wait_edges(1);
    RESETn = 1'b0;
    #1;
    check_out("async_sysrst", 1'b0, 1'b0, 2'b01);
    wait_edges(2);
    RESETn = 1'b1;
    wait_edges(16);
    check_out("resync_e16", 1'b1, 1'b0, 2'b01);
    wait_edges(3);
    check_out("resync_e19", 1'b1, 1'b1, 2'b01);

    // Randomized traffic; the reference model checks every cycle.
    rst_hold = 0;
    lk = 2'b11;
    for (int c = 0; c < 4000; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        RESETn = (rst_hold == 0);
      end else if ($urandom_range(0, 399) == 0) begin
        rst_hold = $urandom_range(1, 3);
        RESETn = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
        if (lk[b] && $urandom_range(0, 79) == 0) lk[b] = 1'b0;
        else if (!lk[b] && $urandom_range(0, 2) == 0) lk[b] = 1'b1;
      end
      PLL_LOCKED  = lk;
      SYSRESETREQ = ($urandom_range(0, 19) == 0);
      wait_edges(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
